vga_text_vram: RTL and testbench

//  Text-mode video RAM feeding the VGA text renderer: 32 rows x 64 cols of 19-bit cells.

---
 rtl/vga_text_pkg.sv | 30 +++
 rtl/vga_text_vram_if.sv | 21 ++
 rtl/vga_text_vram_array.sv | 40 ++++
 rtl/vga_text_vram.sv | 133 +++++++++++++
 tb/tb_vga_text_vram.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants, cell/index types and engine state encoding for the text-mode VRAM.
package vga_text_pkg;

    localparam int COLS_LG2 = 6;
    localparam int ROWS_LG2 = 5;
    localparam int COLS     = 1 << COLS_LG2;
    localparam int ROWS     = 1 << ROWS_LG2;
    localparam int CELLS    = COLS * ROWS;
    localparam int IDX_W    = COLS_LG2 + ROWS_LG2;
    localparam int CELL_W   = 19;

    localparam int CMD_CLEAR  = 0;
    localparam int CMD_SCROLL = 1;
    localparam logic [15:0] BLANK_CHAR = 16'h0020;

    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLEAR    = 2'd1,
        ST_SCR_COPY = 2'd2,
        ST_SCR_FILL = 2'd3
    } state_t;

    function automatic cell_t fill_cell(input logic [2:0] colour);
        return {colour, BLANK_CHAR};
    endfunction

endpackage

// File: rtl/vga_text_vram_if.sv
// CPU-side bus of the text VRAM: single-request access with a one-cycle ready pulse.
interface vga_text_vram_if;

    logic        cpu_cs;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready
    );

endinterface

// File: rtl/vga_text_vram_array.sv
// 2048x19 cell store: a private VGA read port plus one read and one write port for CPU/engines.
// All reads are read-first; only the output registers are reset, never the array.
module vga_text_vram_array
    import vga_text_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  vga_re_i,
    input  idx_t  vga_idx_i,
    output cell_t vga_data_o,
    input  logic  rd_en_i,
    input  idx_t  rd_idx_i,
    output cell_t rd_data_o,
    input  logic  we_i,
    input  idx_t  wr_idx_i,
    input  cell_t wr_data_i
);

    cell_t mem_q [CELLS];
    cell_t vga_data_q;
    cell_t rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[wr_idx_i] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_data_q <= '0;
            rd_data_q  <= '0;
        end else begin
            if (vga_re_i) vga_data_q <= mem_q[vga_idx_i];
            if (rd_en_i)  rd_data_q  <= mem_q[rd_idx_i];
        end
    end

    assign vga_data_o = vga_data_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/vga_text_vram.sv
// Text-mode VRAM top: CPU bus decode, clear/scroll engine FSM and index counter.
// VGA_TEXT_SCROLL_EN builds the scroll-up engine; without it only CLEAR exists.
module vga_text_vram
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       vga_addr,
    input  logic              vga_rdn,
    output logic [CELL_W-1:0] vram_out,
    vga_text_vram_if.slave    bus,
    output logic              busy
);

    localparam idx_t LAST_IDX = idx_t'(CELLS - 1);
`ifdef VGA_TEXT_SCROLL_EN
    localparam idx_t COPY_END = idx_t'(CELLS - COLS);
    localparam idx_t ROW_STEP = idx_t'(COLS);
`endif

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    cell_t  fill_q, fill_d;
    logic   ready_q, ready_d;
    logic   rd_vram_q, rd_vram_d;
    logic   status_q, status_d;

    logic  arr_we, arr_rd_en;
    idx_t  arr_wr_idx, arr_rd_idx;
    cell_t arr_wr_data, arr_rd_data;

    idx_t cpu_idx;
    logic unused_bits;

    assign cpu_idx     = bus.cpu_addr[2 +: IDX_W];
    assign unused_bits = ^{vga_addr[31:13], vga_addr[1:0], bus.cpu_wdata[31:CELL_W], bus.cpu_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        ready_d     = 1'b0;
        rd_vram_d   = rd_vram_q;
        status_d    = status_q;
        arr_we      = 1'b0;
        arr_wr_idx  = idx_q;
        arr_wr_data = fill_q;
        arr_rd_en   = 1'b0;
        arr_rd_idx  = cpu_idx;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_cs) begin
                    ready_d = 1'b1;
                    if (bus.cpu_addr[13]) begin
                        if (bus.cpu_we) begin
                            fill_d = fill_cell(bus.cpu_wdata[10:8]);
                            if (bus.cpu_wdata[CMD_CLEAR]) state_d = ST_CLEAR;
`ifdef VGA_TEXT_SCROLL_EN
                            else if (bus.cpu_wdata[CMD_SCROLL]) state_d = ST_SCR_COPY;
`endif
                        end else begin
                            rd_vram_d = 1'b0;
                            status_d  = busy;
                        end
                    end else if (bus.cpu_we) begin
                        arr_we      = 1'b1;
                        arr_wr_idx  = cpu_idx;
                        arr_wr_data = bus.cpu_wdata[CELL_W-1:0];
                    end else begin
                        arr_rd_en = 1'b1;
                        rd_vram_d = 1'b1;
                    end
                end
            end
            // The index wraps to 0 on the exit transition, so IDLE always starts an engine at cell 0.
            ST_CLEAR, ST_SCR_FILL: begin
                arr_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
            end
`ifdef VGA_TEXT_SCROLL_EN
            // Copy pipeline: read cell idx+64 now, write it to cell idx at the next step.
            ST_SCR_COPY: begin
                arr_rd_en   = (idx_q != COPY_END);
                arr_rd_idx  = idx_q + ROW_STEP;
                arr_we      = (idx_q != '0);
                arr_wr_idx  = idx_q - 1'b1;
                arr_wr_data = arr_rd_data;
                if (idx_q == COPY_END) state_d = ST_SCR_FILL;
                else                   idx_d   = idx_q + 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            fill_q    <= '0;
            ready_q   <= 1'b0;
            rd_vram_q <= 1'b0;
            status_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fill_q    <= fill_d;
            ready_q   <= ready_d;
            rd_vram_q <= rd_vram_d;
            status_q  <= status_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign bus.cpu_ready = ready_q;
    assign bus.cpu_rdata = rd_vram_q ? {{(32-CELL_W){1'b0}}, arr_rd_data} : {31'b0, status_q};

    vga_text_vram_array u_array (
        .clk        (clk),
        .rst_n      (reset_n),
        .vga_re_i   (!vga_rdn),
        .vga_idx_i  (vga_addr[2 +: IDX_W]),
        .vga_data_o (vram_out),
        .rd_en_i    (arr_rd_en),
        .rd_idx_i   (arr_rd_idx),
        .rd_data_o  (arr_rd_data),
        .we_i       (arr_we),
        .wr_idx_i   (arr_wr_idx),
        .wr_data_i  (arr_wr_data)
    );

endmodule

// File: tb/tb_vga_text_vram.sv
// Scoreboard bench for vga_text_vram: CPU/VGA expectations queued at issue, checked by monitors.
module tb_vga_text_vram;
    import vga_text_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       vga_addr;
    logic              vga_rdn;
    logic [CELL_W-1:0] vram_out;
    logic              busy;

    vga_text_vram_if bus();

    vga_text_vram dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .vga_addr (vga_addr),
        .vga_rdn  (vga_rdn),
        .vram_out (vram_out),
        .bus      (bus),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
    } cpu_exp_t;

    cpu_exp_t          cpu_q[$];
    logic [CELL_W-1:0] vga_q[$];
    logic [CELL_W-1:0] mdl   [CELLS];
    bit                known [CELLS];
    int                total = 0;
    int                bad   = 0;
    bit                vga_pend = 1'b0;
    cpu_exp_t          cpu_e;
    logic [CELL_W-1:0] vga_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: a VGA read sampled at a rising edge is compared at the following falling edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) vga_pend <= 1'b0;
        else          vga_pend <= !vga_rdn;
    end

    always @(negedge clk) begin
        if (bus.cpu_ready === 1'b1) begin
            if (cpu_q.size() == 0) begin
                total++; bad++;
                $display("FAIL cpu_ready: pulse with no access outstanding at %0t", $time);
            end else begin
                cpu_e = cpu_q.pop_front();
                if (cpu_e.chk) check("cpu_rdata", bus.cpu_rdata, cpu_e.exp);
            end
        end
        if (vga_pend) begin
            if (vga_q.size() == 0) begin
                total++; bad++;
                $display("FAIL vram_out: read with no expectation at %0t", $time);
            end else begin
                vga_e = vga_q.pop_front();
                check("vram_out", {13'b0, vram_out}, {13'b0, vga_e});
            end
        end
    end

    task automatic cpu_acc(input bit we, input logic [13:0] addr, input logic [31:0] wd);
        cpu_exp_t e;
        int idx, n;
        idx   = int'(addr[12:2]);
        e.chk = 1'b0;
        e.exp = '0;
        if (addr[13]) begin
            if (!we) begin e.chk = 1'b1; e.exp = 32'h0; end
        end else if (we) begin
            mdl[idx]   = wd[CELL_W-1:0];
            known[idx] = 1'b1;
        end else if (known[idx]) begin
            e.chk = 1'b1;
            e.exp = {13'b0, mdl[idx]};
        end
        cpu_q.push_back(e);
        @(negedge clk);
        bus.cpu_cs = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            check("no_ready_while_stalled", {31'b0, bus.cpu_ready}, 32'h0);
        end
        if (n >= 6000) begin
            total++; bad++;
            $display("FAIL stall_timeout: busy still %b after %0d cycles", busy, n);
        end
        @(posedge clk); #1;
        bus.cpu_cs = 1'b0;
        @(negedge clk);
        check("cpu_ready_t1", {31'b0, bus.cpu_ready}, 32'h1);
    endtask

    task automatic cmd(input logic [31:0] wd);
        logic [CELL_W-1:0] f;
        int exp_busy, n;
        f        = fill_cell(wd[10:8]);
        exp_busy = 0;
        cpu_acc(1'b1, 14'h2000, wd);
        if (wd[CMD_CLEAR]) begin
            for (int i = 0; i < CELLS; i++) begin mdl[i] = f; known[i] = 1'b1; end
            exp_busy = CELLS;
        end
`ifdef VGA_TEXT_SCROLL_EN
        else if (wd[CMD_SCROLL]) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    if (r < ROWS - 1) begin
                        mdl[r*COLS + c]   = mdl[(r+1)*COLS + c];
                        known[r*COLS + c] = known[(r+1)*COLS + c];
                    end else begin
                        mdl[r*COLS + c]   = f;
                        known[r*COLS + c] = 1'b1;
                    end
                end
            exp_busy = (CELLS - COLS + 1) + COLS;
        end
`endif
        n = 0;
        while (busy === 1'b1 && n < 6000) begin n++; @(negedge clk); end
        check("busy_cycles", n, exp_busy);
    endtask

    task automatic vga_issue(input int idx, input logic [CELL_W-1:0] exp);
        logic [31:0] r;
        r = $urandom;
        @(negedge clk);
        vga_addr = {r[31:13], 11'(idx), r[1:0]};
        vga_rdn  = 1'b0;
        vga_q.push_back(exp);
    endtask

    task automatic vga_idle();
        @(negedge clk);
        vga_rdn = 1'b1;
    endtask

    task automatic vga_sweep();
        for (int i = 0; i < CELLS; i++)
            if (known[i]) vga_issue(i, mdl[i]);
        vga_idle();
        @(negedge clk);
        check("vga_drained", vga_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CELL_W-1:0] oldv, newv;
        int op, idx;
        logic [31:0] rd;

        reset_n = 1'b0; vga_rdn = 1'b1; vga_addr = '0;
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < CELLS; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      {31'b0, busy}, 32'h0);
        check("rst_vram_out",  {13'b0, vram_out}, 32'h0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("rst_cpu_ready", {31'b0, bus.cpu_ready}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single write then read back over both ports; cell 65 is row 1 col 1.
        cpu_acc(1'b1, 14'h0104, 32'h0005_0041);
        vga_issue(65, 19'h5_0041);
        vga_idle();
        cpu_acc(1'b0, 14'h0104, 32'h0);
        cpu_acc(1'b0, 14'h2000, 32'h0);

        // Clear with colour 2 while a CPU read waits behind it.
        fork
            cmd(32'h0000_0201);
            begin
                repeat (300) @(negedge clk);
                cpu_acc(1'b0, 14'h0104, 32'h0);
            end
        join
        vga_sweep();

        for (int k = 0; k < 400; k++) begin
            op  = $urandom_range(0, 3);
            idx = $urandom_range(0, CELLS - 1);
            rd  = $urandom;
            case (op)
                0: cpu_acc(1'b1, 14'(idx * 4) | 14'(rd[1:0]), rd);
                1: cpu_acc(1'b0, 14'(idx * 4), 32'h0);
                2: begin vga_issue(idx, mdl[idx]); vga_idle(); end
                default: cpu_acc(1'b0, 14'h2000, 32'h0);
            endcase
        end

        // Same-edge CPU write and VGA read of cell 0, then hold while disabled.
        cpu_acc(1'b1, 14'h0000, 32'h0001_1111);
        oldv = mdl[0];
        newv = 19'h3_BEEF;
        fork
            cpu_acc(1'b1, 14'h0000, {13'b0, newv});
            begin
                vga_issue(0, oldv);
                vga_issue(0, newv);
                vga_idle();
            end
        join
        cpu_acc(1'b1, 14'h0000, 32'h0004_4444);
        repeat (3) @(negedge clk);
        check("vga_hold", {13'b0, vram_out}, {13'b0, newv});

        // Both command bits: only the clear runs.
        cmd(32'h0000_0003);
        vga_sweep();
        cmd(32'h0000_0000);

`ifdef VGA_TEXT_SCROLL_EN
        for (int i = 0; i < CELLS; i++) cpu_acc(1'b1, 14'(i * 4), {13'b0, 3'd1, 16'(i)});
        cmd(32'h0000_0702);
        vga_sweep();
        for (int k = 0; k < 100; k++) begin
            idx = $urandom_range(0, CELLS - 1);
            cpu_acc(1'b1, 14'(idx * 4), $urandom);
        end
        rd = $urandom;
        cmd({21'b0, rd[2:0], 8'h02});
        vga_sweep();
`else
        cmd(32'h0000_0002);
        vga_sweep();
`endif

        // Reset while clearing: cells 0..999 get the fill, the rest keep their contents.
        cpu_acc(1'b1, 14'(1500 * 4), 32'h0006_1234);
        cpu_acc(1'b0, 14'(1500 * 4), 32'h0);
        vga_issue(1500, mdl[1500]);
        vga_idle();
        cpu_acc(1'b1, 14'h2000, 32'h0000_0501);
        repeat (1000) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_busy",      {31'b0, busy}, 32'h0);
        check("midrst_vram_out",  {13'b0, vram_out}, 32'h0);
        check("midrst_cpu_rdata", bus.cpu_rdata, 32'h0);
        check("midrst_cpu_ready", {31'b0, bus.cpu_ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 1000; i++) mdl[i] = fill_cell(3'd5);
        repeat (3) @(negedge clk);
        check("busy_after_rst", {31'b0, busy}, 32'h0);
        vga_sweep();

        repeat (5) @(negedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
